// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - instruction fetch and datapath strobe bundle for instr_sequencer
interface instr_sequencer_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [31:0]     ir_out;
  logic            ir_valid;
  logic            exec_done;
  logic            flag_sign;
  logic            flag_zero;
  logic            flag_carry;
  logic            flag_overflow;

  modport master (
    output imem_req, imem_addr, ir_out, ir_valid,
    input  imem_ack, imem_rdata, exec_done,
    input  flag_sign, flag_zero, flag_carry, flag_overflow
  );

  modport slave (
    input  imem_req, imem_addr, ir_out, ir_valid,
    output imem_ack, imem_rdata, exec_done,
    output flag_sign, flag_zero, flag_carry, flag_overflow
  );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute controller for the 16-bit GPR datapath
module instr_sequencer #(
  parameter int PC_W          = 8,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             start,
  instr_sequencer_if.master bus,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [15:0]      instr_count
);

  localparam int TO_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

  localparam logic [4:0] OP_JMP = 5'b01100;
  localparam logic [4:0] OP_JC  = 5'b01101;
  localparam logic [4:0] OP_JNC = 5'b01110;
  localparam logic [4:0] OP_JS  = 5'b01111;
  localparam logic [4:0] OP_JZ  = 5'b10000;
  localparam logic [4:0] OP_JV  = 5'b10001;
  localparam logic [4:0] OP_HLT = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            f_sign;
  logic            f_zero;
  logic            f_carry;
  logic            f_ovf;

  logic [4:0]      opcode;
  logic [PC_W-1:0] target;
  logic            is_branch;
  logic            is_halt;
  logic            take;

  assign opcode        = bus.ir_out[31:27];
  assign target        = bus.ir_out[PC_W-1:0];
  assign bus.imem_addr = pc;

  // Branch conditions look only at flags latched from the last completed datapath op.
  always_comb begin
    is_branch = 1'b1;
    take      = 1'b0;
    case (opcode)
      OP_JMP:  take = 1'b1;
      OP_JC:   take = f_carry;
      OP_JNC:  take = ~f_carry;
      OP_JS:   take = f_sign;
      OP_JZ:   take = f_zero;
      OP_JV:   take = f_ovf;
      default: is_branch = 1'b0;
    endcase
    is_halt = (opcode == OP_HLT);
  end

  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      state        <= S_IDLE;
      pc           <= '0;
      bus.ir_out   <= '0;
      bus.ir_valid <= 1'b0;
      bus.imem_req <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      fault        <= 1'b0;
      instr_count  <= '0;
      to_cnt       <= '0;
      f_sign       <= 1'b0;
      f_zero       <= 1'b0;
      f_carry      <= 1'b0;
      f_ovf        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state        <= S_FETCH;
            pc           <= '0;
            fault        <= 1'b0;
            instr_count  <= '0;
            to_cnt       <= '0;
            bus.imem_req <= 1'b1;
            busy         <= 1'b1;
            halted       <= 1'b0;
          end
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            bus.ir_out   <= bus.imem_rdata;
            bus.imem_req <= 1'b0;
            to_cnt       <= '0;
            state        <= S_DECODE;
          end else if (to_cnt == TO_LAST) begin
            fault        <= 1'b1;
            bus.imem_req <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b1;
            to_cnt       <= '0;
            state        <= S_HALT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_DECODE: begin
          if (is_branch) begin
            pc           <= take ? target : pc + PC_W'(1);
            bus.imem_req <= 1'b1;
            state        <= S_FETCH;
            if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
          end else if (is_halt) begin
            busy   <= 1'b0;
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            bus.ir_valid <= 1'b1;
            state        <= S_EXEC;
          end
        end
        S_EXEC: begin
          bus.ir_valid <= 1'b0;
          if (bus.exec_done) begin
            f_sign       <= bus.flag_sign;
            f_zero       <= bus.flag_zero;
            f_carry      <= bus.flag_carry;
            f_ovf        <= bus.flag_overflow;
            pc           <= pc + PC_W'(1);
            bus.imem_req <= 1'b1;
            state        <= S_FETCH;
            if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

  localparam logic [4:0] OP_MOV = 5'b00001;
  localparam logic [4:0] OP_ADD = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00100;
  localparam logic [4:0] OP_JMP = 5'b01100;
  localparam logic [4:0] OP_JZ  = 5'b10000;
  localparam logic [4:0] OP_HLT = 5'b11111;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        start8;
  logic        start4;
  logic        ack8_en;
  logic        log4_en;
  logic [7:0]  pc8;
  logic        busy8, halted8, fault8;
  logic [15:0] cnt8;
  logic [3:0]  pc4;
  logic        busy4, halted4, fault4;
  logic [15:0] cnt4;
  logic [31:0] mem8 [256];
  logic [31:0] mem4 [16];
  logic [3:0]  fetch_log [$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  instr_sequencer_if #(.PC_W(8)) bus8 ();
  instr_sequencer_if #(.PC_W(4)) bus4 ();

  assign bus8.imem_ack   = ack8_en & bus8.imem_req;
  assign bus8.imem_rdata = mem8[bus8.imem_addr];
  assign bus4.imem_ack   = bus4.imem_req;
  assign bus4.imem_rdata = mem4[bus4.imem_addr];

  instr_sequencer #(.PC_W(8), .FETCH_TIMEOUT(15)) u8 (
    .clk(clk), .sys_rst(sys_rst), .start(start8), .bus(bus8),
    .pc(pc8), .busy(busy8), .halted(halted8), .fault(fault8), .instr_count(cnt8)
  );

  instr_sequencer #(.PC_W(4), .FETCH_TIMEOUT(15)) u4 (
    .clk(clk), .sys_rst(sys_rst), .start(start4), .bus(bus4),
    .pc(pc4), .busy(busy4), .halted(halted4), .fault(fault4), .instr_count(cnt4)
  );

  always @(negedge clk) begin
    if (log4_en && bus4.imem_req) fetch_log.push_back(bus4.imem_addr);
  end

  function automatic logic [31:0] ins(input logic [4:0] op, input logic [26:0] arg);
    return {op, arg};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start from IDLE/HALT at cycle 0; z is the zero flag at exec_done, inverted before the branch decodes.
  task automatic run_branch(input logic z, input logic [7:0] exp_addr, input string tag);
    mem8[0] = ins(OP_ADD, 27'h0000101);
    mem8[1] = ins(OP_JZ, 27'd8);
    mem8[2] = ins(OP_HLT, 27'd0);
    mem8[8] = ins(OP_HLT, 27'd0);
    bus8.flag_zero = z;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    bus8.flag_zero = ~z;
    tick(); tick();
    chk({tag, "_req"}, bus8.imem_req, 1'b1);
    chk({tag, "_addr"}, bus8.imem_addr, exp_addr);
    tick(); tick();
    chk({tag, "_halted"}, halted8, 1'b1);
    chk({tag, "_pc"}, pc8, exp_addr);
    chk({tag, "_count"}, cnt8, 16'd2);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem8[i] = 32'h0;
    for (int i = 0; i < 16; i++) mem4[i] = 32'h0;
    sys_rst = 1'b0;
    start8 = 1'b0;
    start4 = 1'b0;
    ack8_en = 1'b1;
    log4_en = 1'b0;
    bus8.exec_done = 1'b1;
    bus8.flag_sign = 1'b0;
    bus8.flag_zero = 1'b0;
    bus8.flag_carry = 1'b0;
    bus8.flag_overflow = 1'b0;
    bus4.exec_done = 1'b1;
    bus4.flag_sign = 1'b0;
    bus4.flag_zero = 1'b0;
    bus4.flag_carry = 1'b0;
    bus4.flag_overflow = 1'b0;
    tick(); tick();
    sys_rst = 1'b1;

    chk("rst_pc", pc8, 8'd0);
    chk("rst_ir", bus8.ir_out, 32'd0);
    chk("rst_irv", bus8.ir_valid, 1'b0);
    chk("rst_req", bus8.imem_req, 1'b0);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_halted", halted8, 1'b0);
    chk("rst_fault", fault8, 1'b0);
    chk("rst_count", cnt8, 16'd0);

    // Straight-line ADD/MOV/OR/HLT
    mem8[0] = ins(OP_ADD, 27'h0012345);
    mem8[1] = ins(OP_MOV, 27'h0000a0b);
    mem8[2] = ins(OP_OR, 27'h0100c0d);
    mem8[3] = ins(OP_HLT, 27'd0);
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("sl_busy", busy8, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("sl_irv_c%0d", c), bus8.ir_valid, (c % 3 == 0) && (c <= 9));
      if ((c % 3 == 0) && (c <= 9)) chk($sformatf("sl_ir_c%0d", c), bus8.ir_out, mem8[c / 3 - 1]);
      if (c < 12) tick();
    end
    chk("sl_halted", halted8, 1'b1);
    chk("sl_busy_end", busy8, 1'b0);
    chk("sl_pc", pc8, 8'd3);
    chk("sl_count", cnt8, 16'd3);

    run_branch(1'b1, 8'd8, "jz_taken");
    run_branch(1'b0, 8'd2, "jz_not");

    // Fetch timeout
    mem8[0] = ins(OP_HLT, 27'd0);
    ack8_en = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    chk("to_req_c15", bus8.imem_req, 1'b1);
    chk("to_fault_c15", fault8, 1'b0);
    tick();
    chk("to_fault", fault8, 1'b1);
    chk("to_halted", halted8, 1'b1);
    chk("to_req", bus8.imem_req, 1'b0);
    chk("to_busy", busy8, 1'b0);
    ack8_en = 1'b1;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("to_restart_fault", fault8, 1'b0);
    chk("to_restart_req", bus8.imem_req, 1'b1);
    chk("to_restart_addr", bus8.imem_addr, 8'd0);
    tick(); tick();
    chk("to_restart_halted", halted8, 1'b1);

    // Multicycle exec: exec_done four cycles after ir_valid
    mem8[0] = ins(OP_ADD, 27'h00055aa);
    mem8[1] = ins(OP_HLT, 27'd0);
    bus8.exec_done = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    chk("mc_irv_c3", bus8.ir_valid, 1'b1);
    chk("mc_ir_c3", bus8.ir_out, 32'h100055aa);
    for (int c = 4; c <= 7; c++) begin
      tick();
      chk($sformatf("mc_irv_c%0d", c), bus8.ir_valid, 1'b0);
      chk($sformatf("mc_ir_c%0d", c), bus8.ir_out, 32'h100055aa);
      chk($sformatf("mc_pc_c%0d", c), pc8, 8'd0);
    end
    bus8.exec_done = 1'b1;
    tick();
    chk("mc_pc_after", pc8, 8'd1);
    chk("mc_count", cnt8, 16'd1);
    chk("mc_req", bus8.imem_req, 1'b1);
    tick(); tick();
    chk("mc_halted", halted8, 1'b1);

    // Reset while ir_valid is outstanding
    mem8[0] = ins(OP_JMP, 27'd5);
    mem8[5] = ins(OP_OR, 27'h0000777);
    bus8.exec_done = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mr_irv_pre", bus8.ir_valid, 1'b1);
    chk("mr_pc_pre", pc8, 8'd5);
    sys_rst = 1'b0;
    tick(); tick();
    sys_rst = 1'b1;
    bus8.exec_done = 1'b1;
    chk("mr_pc", pc8, 8'd0);
    chk("mr_ir", bus8.ir_out, 32'd0);
    chk("mr_irv", bus8.ir_valid, 1'b0);
    chk("mr_req", bus8.imem_req, 1'b0);
    chk("mr_busy", busy8, 1'b0);
    chk("mr_halted", halted8, 1'b0);
    chk("mr_fault", fault8, 1'b0);
    chk("mr_count", cnt8, 16'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("mr_post_irv_%0d", c), bus8.ir_valid, 1'b0);
      chk($sformatf("mr_post_busy_%0d", c), busy8, 1'b0);
    end

    // PC wrap on the 4-bit instance: 0 JMP 7, 7 JMP 15, 15 ADD, then 0
    mem4[0] = ins(OP_JMP, 27'd7);
    mem4[7] = ins(OP_JMP, 27'd15);
    mem4[15] = ins(OP_ADD, 27'h0000321);
    log4_en = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    log4_en = 1'b0;
    chk("wrap_nfetch", fetch_log.size() >= 4, 1'b1);
    if (fetch_log.size() >= 4) begin
      chk("wrap_f0", fetch_log[0], 4'd0);
      chk("wrap_f1_jmp7", fetch_log[1], 4'd7);
      chk("wrap_f2", fetch_log[2], 4'd15);
      chk("wrap_f3_wrap", fetch_log[3], 4'd0);
    end
    sys_rst = 1'b0;
    tick();
    sys_rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
